tag_cache_mem_arbiter: RTL

Round-robin arbiter sharing the single backing-memory port between the tag cache's requesters: data refill/writeback and tag refill/writeback. Read requests are single-beat commands. Write requests are fixed-length bursts that lock the grant until the last beat is accepted. Read responses return tagged with a requester id and are routed back to the originating requester. It sits between the tag cache's memory-side interfaces and the memory driver/behavioural memory.

---
 rtl/tag_cache_mem_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/tag_cache_mem_arbiter.sv
// Round-robin arbiter sharing one backing-memory port between tag-cache
// requesters. Reads are single-beat commands; write bursts lock the grant
// until the last beat is accepted. Read responses are routed by id.
module tag_cache_mem_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 64,
  parameter int unsigned BEATS = 4,
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_req_write,
  output logic [AW-1:0]      mem_req_addr,
  output logic [DW-1:0]      mem_req_data,
  output logic [IDW-1:0]     mem_req_id,
  input  logic               mem_resp_valid,
  output logic               mem_resp_ready,
  input  logic [IDW-1:0]     mem_resp_id,
  input  logic [DW-1:0]      mem_resp_data,
  input  logic               mem_resp_last,
  output logic [NREQ-1:0]    resp_valid,
  output logic [DW-1:0]      resp_data,
  output logic               resp_last,
  input  logic [NREQ-1:0]    resp_ready
);

  localparam int unsigned BW = $clog2(BEATS);

  typedef enum logic {
    S_IDLE,
    S_WBURST
  } state_t;

  state_t         r_state, w_state_n;
  logic [IDW-1:0] r_prio,  w_prio_n;
  logic [IDW-1:0] r_gnt,   w_gnt_n;
  logic [BW-1:0]  r_beat,  w_beat_n;

  logic [IDW-1:0] w_winner;
  logic           w_any;
  logic [IDW-1:0] w_sel;
  logic           w_rd_in_burst;
  logic           w_hs;
  int unsigned    w_idx;

  // Pointer increment with explicit wrap so non-power-of-two NREQ works.
  function automatic logic [IDW-1:0] f_inc(input logic [IDW-1:0] x);
    return (32'(x) == NREQ - 1) ? '0 : x + IDW'(1);
  endfunction

  // Round-robin scan: first valid requester at or after the priority pointer.
  always_comb begin
    w_winner = '0;
    w_any    = 1'b0;
    w_idx    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = (32'(r_prio) + k) % NREQ;
      if (!w_any && req_valid[w_idx]) begin
        w_any    = 1'b1;
        w_winner = IDW'(w_idx);
      end
    end
  end

  // Request datapath: forward the winner in IDLE, the locked requester in a burst.
  always_comb begin
    w_sel         = (r_state == S_IDLE) ? w_winner : r_gnt;
    mem_req_write = req_write[w_sel];
    mem_req_addr  = req_addr[32'(w_sel)*AW +: AW];
    mem_req_data  = req_data[32'(w_sel)*DW +: DW];
    mem_req_id    = w_sel;
    mem_req_valid = 1'b0;
    req_ready     = '0;
    // A read from the locked requester mid-burst stalls rather than interleaving.
    w_rd_in_burst = req_valid[r_gnt] && !req_write[r_gnt];
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          mem_req_valid       = w_any;
          req_ready[w_winner] = mem_req_ready && w_any;
        end
        S_WBURST: begin
          mem_req_valid    = req_valid[r_gnt] && !w_rd_in_burst;
          req_ready[r_gnt] = mem_req_ready && !w_rd_in_burst;
        end
        default: ;
      endcase
    end
    w_hs = mem_req_valid && mem_req_ready;
  end

  // Next-state logic: read handshakes rotate priority, writes lock the grant.
  always_comb begin
    w_state_n = r_state;
    w_prio_n  = r_prio;
    w_gnt_n   = r_gnt;
    w_beat_n  = r_beat;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          if (mem_req_write) begin
            w_gnt_n   = w_winner;
            w_beat_n  = BW'(1);
            w_state_n = S_WBURST;
          end else begin
            w_prio_n = f_inc(w_winner);
          end
        end
      end
      S_WBURST: begin
        if (w_hs) begin
          if (r_beat == BW'(BEATS - 1)) begin
            w_prio_n  = f_inc(r_gnt);
            w_beat_n  = '0;
            w_state_n = S_IDLE;
          end else begin
            w_beat_n = r_beat + BW'(1);
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Arbitration state register; reset abandons any burst in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_prio  <= '0;
      r_gnt   <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_n;
      r_prio  <= w_prio_n;
      r_gnt   <= w_gnt_n;
      r_beat  <= w_beat_n;
    end
  end

  // Response routing by id; out-of-range ids are accepted and dropped.
  always_comb begin
    resp_valid     = '0;
    mem_resp_ready = 1'b0;
    resp_data      = mem_resp_data;
    resp_last      = mem_resp_last;
    if (!rst) begin
      if (32'(mem_resp_id) < NREQ) begin
        resp_valid[mem_resp_id] = mem_resp_valid;
        mem_resp_ready          = resp_ready[mem_resp_id];
      end else begin
        mem_resp_ready = 1'b1;
      end
    end
  end

endmodule
